// File: rtl/be_pkg.sv
// Bus-engine types shared by the memory bus arbiter and its round-robin selector.
package be_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_ACCESS = 2'd1,
        BUS_RESP   = 2'd2
    } BUS_ARB_STATE_t;

    typedef enum logic {
        BUS_REQ_CORE = 1'b0,
        BUS_REQ_LDR  = 1'b1
    } BUS_REQ_ID_t;

    localparam int unsigned BUS_CNT_W = 16;

    function automatic logic bus_is_req(input logic rden, input logic wren);
        return rden | wren;
    endfunction

endpackage

// File: rtl/rv32i_pkg.sv
// Shared RV32I type definitions used across the core and memory subsystem.
package rv32i_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-way round-robin selector: on a tie the port not granted last wins.
module bus_rr_arbiter
    import be_pkg::*;
(
    input  logic        core_req_i,
    input  logic        ldr_req_i,
    input  BUS_REQ_ID_t last_grant_i,
    output logic [1:0]  grant_o
);

    // grant_o[0] selects the core, grant_o[1] the loader
    always_comb begin
        grant_o = 2'b00;
        if (core_req_i && ldr_req_i) begin
            grant_o = (last_grant_i == BUS_REQ_LDR) ? 2'b01 : 2'b10;
        end else if (core_req_i) begin
            grant_o = 2'b01;
        end else if (ldr_req_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the core and the loader with round-robin
// arbitration, a per-transaction ACCESS timeout and a sticky bus error flag.
module mem_bus_arbiter
    import rv32i_pkg::*;
    import be_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  RV32I_OPERAND_t        core_wrdata,
    input  logic                  core_rden,
    input  logic                  core_wren,
    output RV32I_OPERAND_t        core_rddata,
    output logic                  core_ack,
    output logic                  core_stall,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  RV32I_OPERAND_t        ldr_wrdata,
    input  logic                  ldr_rden,
    input  logic                  ldr_wren,
    output RV32I_OPERAND_t        ldr_rddata,
    output logic                  ldr_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output RV32I_OPERAND_t        mem_wrdata,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  RV32I_OPERAND_t        mem_rddata,
    input  logic                  mem_ready,
    output logic                  bus_err
);

    localparam int unsigned            TO_LAST = TIMEOUT_CYCLES - 1;
    localparam logic [BUS_CNT_W-1:0]   CNT_ONE = {{(BUS_CNT_W-1){1'b0}}, 1'b1};

    BUS_ARB_STATE_t        state_q, state_d;
    BUS_REQ_ID_t           win_q, win_d;
    BUS_REQ_ID_t           last_grant_q, last_grant_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    RV32I_OPERAND_t        wdata_q, wdata_d;
    logic [BUS_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  core_ack_q, core_ack_d;
    logic                  ldr_ack_q, ldr_ack_d;
    RV32I_OPERAND_t        core_rd_q, core_rd_d;
    RV32I_OPERAND_t        ldr_rd_q, ldr_rd_d;

    logic                  core_req, ldr_req;
    logic [1:0]            grant;
    logic                  timeout_hit;
    logic                  load_rd;
    RV32I_OPERAND_t        rd_val;

    assign core_req = bus_is_req(core_rden, core_wren);
    assign ldr_req  = bus_is_req(ldr_rden, ldr_wren);

    bus_rr_arbiter u_rr (
        .core_req_i   (core_req),
        .ldr_req_i    (ldr_req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // mem_ready beats the timeout when both land in the same cycle
    assign timeout_hit = ({{(32-BUS_CNT_W){1'b0}}, cnt_q} == TO_LAST);
    assign load_rd     = mem_ready ? ~wr_q : 1'b1;
    assign rd_val      = mem_ready ? mem_rddata : '0;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        core_ack_d   = 1'b0;
        ldr_ack_d    = 1'b0;
        core_rd_d    = core_rd_q;
        ldr_rd_d     = ldr_rd_q;
        unique case (state_q)
            BUS_IDLE: begin
                if (grant[0]) begin
                    win_d   = BUS_REQ_CORE;
                    addr_d  = core_addr;
                    wdata_d = core_wrdata;
                    wr_d    = core_wren;
                end else if (grant[1]) begin
                    win_d   = BUS_REQ_LDR;
                    addr_d  = ldr_addr;
                    wdata_d = ldr_wrdata;
                    wr_d    = ldr_wren;
                end
                if (|grant) begin
                    cnt_d   = '0;
                    state_d = BUS_ACCESS;
                end
            end
            BUS_ACCESS: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mem_ready || timeout_hit) begin
                    state_d = BUS_RESP;
                    err_d   = err_q | ~mem_ready;
                    if (win_q == BUS_REQ_CORE) begin
                        core_ack_d = 1'b1;
                        if (load_rd) core_rd_d = rd_val;
                    end else begin
                        ldr_ack_d = 1'b1;
                        if (load_rd) ldr_rd_d = rd_val;
                    end
                end
            end
            BUS_RESP: begin
                last_grant_d = win_q;
                state_d      = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= BUS_IDLE;
            win_q        <= BUS_REQ_CORE;
            last_grant_q <= BUS_REQ_LDR;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            core_ack_q   <= 1'b0;
            ldr_ack_q    <= 1'b0;
            core_rd_q    <= '0;
            ldr_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            core_ack_q   <= core_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            core_rd_q    <= core_rd_d;
            ldr_rd_q     <= ldr_rd_d;
        end
    end

    // Address/data come straight from the grant registers, so they hold outside ACCESS
    assign mem_addr    = addr_q;
    assign mem_wrdata  = wdata_q;
    assign mem_rden    = (state_q == BUS_ACCESS) & ~wr_q;
    assign mem_wren    = (state_q == BUS_ACCESS) &  wr_q;
    assign core_ack    = core_ack_q;
    assign ldr_ack     = ldr_ack_q;
    assign core_rddata = core_rd_q;
    assign ldr_rddata  = ldr_rd_q;
    assign bus_err     = err_q;
    assign core_stall  = core_req & ~core_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected
// acks; a negedge monitor checks memory strobes and pops on every ack.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int unsigned ack_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr, core_wrdata, core_rddata;
    logic        core_rden, core_wren, core_ack, core_stall;
    logic [31:0] ldr_addr, ldr_wrdata, ldr_rddata;
    logic        ldr_rden, ldr_wren, ldr_ack;
    logic [31:0] mem_addr, mem_wrdata;
    logic [31:0] mem_rddata = 32'h0;
    logic        mem_rden, mem_wren;
    logic        mem_ready = 1'b0;
    logic        bus_err;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned rdy_delay = 0;
    int unsigned acc_cnt = 0;
    logic        idle_ready = 1'b0;

    mem_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .core_addr   (core_addr),
        .core_wrdata (core_wrdata),
        .core_rden   (core_rden),
        .core_wren   (core_wren),
        .core_rddata (core_rddata),
        .core_ack    (core_ack),
        .core_stall  (core_stall),
        .ldr_addr    (ldr_addr),
        .ldr_wrdata  (ldr_wrdata),
        .ldr_rden    (ldr_rden),
        .ldr_wren    (ldr_wren),
        .ldr_rddata  (ldr_rddata),
        .ldr_ack     (ldr_ack),
        .mem_addr    (mem_addr),
        .mem_wrdata  (mem_wrdata),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_rddata  (mem_rddata),
        .mem_ready   (mem_ready),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: ready after rdy_delay strobe cycles; 0x100 holds a fixed word, elsewhere ~addr
    always @(negedge clk) begin
        if (mem_rden || mem_wren) begin
            mem_ready <= (acc_cnt >= rdy_delay);
            acc_cnt   <= acc_cnt + 1;
        end else begin
            mem_ready <= idle_ready;
            acc_cnt   <= 0;
        end
        mem_rddata <= (mem_addr == 32'h100) ? 32'h1234_5678 : ~mem_addr;
    end

    always @(negedge clk) begin
        if ((mem_rden || mem_wren) && sbq.size() > 0) begin
            chk("mem_addr", mem_addr, sbq[0].addr);
            chk("mem_wren", 32'(mem_wren), 32'(sbq[0].wr));
            chk("mem_rden", 32'(mem_rden), 32'(!sbq[0].wr));
            if (sbq[0].wr) chk("mem_wrdata", mem_wrdata, sbq[0].wdata);
        end
        if (core_ack || ldr_ack) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'b0, ldr_ack, core_ack}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("dual_ack", 32'(core_ack && ldr_ack), 32'd0);
                chk("ack_port", 32'(ldr_ack), 32'(mon_e.port));
                chk("ack_cycle", cyc, mon_e.ack_cyc);
                chk("rddata", mon_e.port ? ldr_rddata : core_rddata, mon_e.rdata);
                chk("bus_err_at_ack", 32'(bus_err), 32'(mon_e.err));
                if (core_ack) chk("core_stall_at_ack", 32'(core_stall), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic err, input int unsigned ack_cyc);
        exp_t e;
        e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.ack_cyc = ack_cyc;
        sbq.push_back(e);
    endtask

    task automatic core_drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        core_rden = rd; core_wren = wr; core_addr = a; core_wrdata = d;
    endtask

    task automatic ldr_drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        ldr_rden = rd; ldr_wren = wr; ldr_addr = a; ldr_wrdata = d;
    endtask

    task automatic core_wait(input int bound, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = core_ack;
        end
        chk("core_ack_seen", 32'(seen), 32'd1);
        tick();
        if (drop) begin core_rden = 1'b0; core_wren = 1'b0; end
    endtask

    task automatic ldr_wait(input int bound, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            seen = ldr_ack;
        end
        chk("ldr_ack_seen", 32'(seen), 32'd1);
        tick();
        if (drop) begin ldr_rden = 1'b0; ldr_wren = 1'b0; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        rst = 1'b0;
        core_drive(1'b0, 1'b0, 32'h0, 32'h0);
        ldr_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        @(negedge clk);
        chk("rst_core_ack", 32'(core_ack), 32'd0);
        chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        chk("rst_core_rddata", core_rddata, 32'h0);
        chk("rst_ldr_rddata", ldr_rddata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wrdata", mem_wrdata, 32'h0);
        chk("rst_mem_rden", 32'(mem_rden), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        tick();
        rst = 1'b1;

        // Tie straight out of reset: core first, loader ack three cycles later
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h200, 32'h0);
        ldr_drive(1'b1, 1'b0, 32'h300, 32'h0);
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'hFFFF_FDFF, 1'b0, c + 2);
        push(1'b1, 1'b0, 32'h300, 32'h0, 32'hFFFF_FCFF, 1'b0, c + 5);
        fork
            core_wait(20, 1'b1);
            ldr_wait(20, 1'b1);
        join

        // Single core read, ack in the third cycle counting the request cycle
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h100, 32'h0);
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b0, c + 2);
        @(negedge clk);
        chk("core_stall_pending", 32'(core_stall), 32'd1);
        core_wait(10, 1'b1);
        chk("core_rddata_hold", core_rddata, 32'h1234_5678);
        chk("ldr_rddata_hold", ldr_rddata, 32'hFFFF_FCFF);

        // rden and wren together is a write; core rddata unchanged
        tick(); c = cyc;
        core_drive(1'b1, 1'b1, 32'h180, 32'h0BAD_F00D);
        push(1'b0, 1'b1, 32'h180, 32'h0BAD_F00D, 32'h1234_5678, 1'b0, c + 2);
        core_wait(10, 1'b1);

        // Loader write with ready after 5 waits: 6 ACCESS cycles; ready while idle is ignored
        rdy_delay = 5; idle_ready = 1'b1;
        tick(); c = cyc;
        ldr_drive(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D);
        push(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'hFFFF_FCFF, 1'b0, c + 7);
        ldr_wait(20, 1'b1);
        rdy_delay = 0; idle_ready = 1'b0;

        // Back-to-back core reads with one IDLE cycle between them
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h200, 32'h0);
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'hFFFF_FDFF, 1'b0, c + 2);
        core_wait(10, 1'b0);
        core_addr = 32'h300;
        push(1'b0, 1'b0, 32'h300, 32'h0, 32'hFFFF_FCFF, 1'b0, c + 5);
        core_wait(10, 1'b1);

        // Ready on the 16th ACCESS cycle beats the timeout
        rdy_delay = 15;
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h100, 32'h0);
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b0, c + 17);
        core_wait(30, 1'b1);
        chk("no_err_on_late_ready", 32'(bus_err), 32'd0);

        // Loader drops its request mid-ACCESS; the ack still arrives
        rdy_delay = 3;
        tick(); c = cyc;
        ldr_drive(1'b1, 1'b0, 32'h300, 32'h0);
        push(1'b1, 1'b0, 32'h300, 32'h0, 32'hFFFF_FCFF, 1'b0, c + 5);
        tick(); tick();
        ldr_drive(1'b0, 1'b0, 32'h300, 32'h0);
        ldr_wait(20, 1'b1);

        // Timeout: 16 ACCESS cycles, rddata 0, sticky error
        rdy_delay = 1000;
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h200, 32'h0);
        push(1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, c + 17);
        core_wait(30, 1'b1);
        rdy_delay = 0;
        tick(); tick();
        chk("bus_err_sticky", 32'(bus_err), 32'd1);
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h100, 32'h0);
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b1, c + 2);
        core_wait(10, 1'b1);

        // Reset in the second ACCESS cycle aborts without an ack
        rdy_delay = 1000;
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h300, 32'h0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rden_in_access2", 32'(mem_rden), 32'd1);
        tick();
        core_drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abort_mem_rden", 32'(mem_rden), 32'd0);
        chk("abort_mem_wren", 32'(mem_wren), 32'd0);
        chk("abort_core_ack", 32'(core_ack), 32'd0);
        chk("abort_bus_err", 32'(bus_err), 32'd0);
        chk("abort_core_rddata", core_rddata, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b1;
        rdy_delay = 0;

        // Core granted last before reset, yet the tie afterwards goes to the core
        tick(); c = cyc;
        core_drive(1'b1, 1'b0, 32'h100, 32'h0);
        ldr_drive(1'b1, 1'b0, 32'h200, 32'h0);
        push(1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 1'b0, c + 2);
        push(1'b1, 1'b0, 32'h200, 32'h0, 32'hFFFF_FDFF, 1'b0, c + 5);
        fork
            core_wait(20, 1'b1);
            ldr_wait(20, 1'b1);
        join

        tick(); tick(); tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
